// File: rtl/input_conditioner.sv
// input_conditioner
//   Cleans an asynchronous external level (button, switch, off-chip strobe)
//   before it reaches synchronous logic. The input passes through a
//   SYNC_STAGES-deep synchroniser. A new level is accepted only after
//   DEBOUNCE_CYCLES consecutive identical synchronised samples.
//
//   State table:
//     STABLE_LO  | accepted level is 0, watching for a synchronised 1
//     CONFIRM_HI | candidate 1 seen, counting consecutive 1 samples
//     STABLE_HI  | accepted level is 1, watching for a synchronised 0
//     CONFIRM_LO | candidate 0 seen, counting consecutive 0 samples
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//                (release is expected to be synchronous to clk)
//   din_async  raw asynchronous input level
//   level_out  debounced level (registered)
//   rise_pulse one-cycle pulse on level_out 0->1 (registered)
//   fall_pulse one-cycle pulse on level_out 1->0 (registered)
//   busy       high while a candidate level change is being confirmed
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_async,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    STABLE_LO  = 2'd0,
    CONFIRM_HI = 2'd1,
    STABLE_HI  = 2'd2,
    CONFIRM_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchroniser chain; only its last stage is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din_async};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = CONFIRM_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CONFIRM_HI: begin
        // Any bounce back to 0 throws away the partial count.
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = CONFIRM_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CONFIRM_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = (state_q == CONFIRM_HI) || (state_q == CONFIRM_LO);

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  typedef struct {
    bit is_rise;
    int edge_no;
  } ev_t;

  logic clk;
  logic reset;
  logic din_a, din_b;
  logic level_a, rise_a, fall_a, busy_a;
  logic level_b, rise_b, fall_b, busy_b;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int base;
  ev_t q_a[$];
  ev_t q_b[$];

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .din_async(din_a),
    .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .busy(busy_a)
  );

  input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .din_async(din_b),
    .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t edge=%0d)", name, act, exp, $time, edge_cnt);
    end
  endtask

  task automatic push_a(input bit is_rise, input int edge_no);
    ev_t e;
    e.is_rise = is_rise;
    e.edge_no = edge_no;
    q_a.push_back(e);
  endtask

  task automatic push_b(input bit is_rise, input int edge_no);
    ev_t e;
    e.is_rise = is_rise;
    e.edge_no = edge_no;
    q_b.push_back(e);
  endtask

  // Monitors: compare each presented pulse against the queued expectation,
  // and flag an expected pulse whose edge has passed without appearing.
  always @(negedge clk) begin
    if (reset) begin
      if (rise_a && fall_a) check("both_pulses_a", 1, 0);
      if (rise_a || fall_a) begin
        if (q_a.size() == 0) begin
          check("unexpected_pulse_a", int'(rise_a) * 2 + int'(fall_a), 0);
        end else begin
          ev_t e;
          e = q_a.pop_front();
          check("pulse_kind_a", int'(rise_a), int'(e.is_rise));
          check("pulse_edge_a", edge_cnt, e.edge_no);
          check("pulse_level_a", int'(level_a), int'(e.is_rise));
        end
      end else if (q_a.size() > 0 && q_a[0].edge_no < edge_cnt) begin
        ev_t e;
        e = q_a.pop_front();
        check("missed_pulse_a", edge_cnt, e.edge_no);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (rise_b && fall_b) check("both_pulses_b", 1, 0);
      if (rise_b || fall_b) begin
        if (q_b.size() == 0) begin
          check("unexpected_pulse_b", int'(rise_b) * 2 + int'(fall_b), 0);
        end else begin
          ev_t e;
          e = q_b.pop_front();
          check("pulse_kind_b", int'(rise_b), int'(e.is_rise));
          check("pulse_edge_b", edge_cnt, e.edge_no);
          check("pulse_level_b", int'(level_b), int'(e.is_rise));
        end
      end else if (q_b.size() > 0 && q_b[0].edge_no < edge_cnt) begin
        ev_t e;
        e = q_b.pop_front();
        check("missed_pulse_b", edge_cnt, e.edge_no);
      end
    end
  end

  task automatic do_reset();
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    reset = 1'b0;
    din_a = 1'b0;
    din_b = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_level_a", int'(level_a), 0);
    check("reset_busy_a", int'(busy_a), 0);
    check("reset_pulses_a", int'(rise_a) + int'(fall_a), 0);
    check("reset_level_b", int'(level_b), 0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    din_a = 1'b0;
    din_b = 1'b0;

    // Clean rise, defaults.
    do_reset();
    din_a = 1'b1;
    base = edge_cnt;
    push_a(1'b1, base + 6);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("clean_busy", int'(busy_a), int'(k >= 3 && k <= 5));
      check("clean_level", int'(level_a), int'(k >= 6));
      check("clean_rise", int'(rise_a), int'(k == 6));
    end

    // Glitch of DEBOUNCE_CYCLES-1 clocks is rejected.
    do_reset();
    din_a = 1'b1;
    base = edge_cnt;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("glitch_busy", int'(busy_a), int'(k >= 3 && k <= 5));
      check("glitch_level", int'(level_a), 0);
      if (k == 3) din_a = 1'b0;
    end

    // Exactly DEBOUNCE_CYCLES clocks high is accepted, then falls back.
    do_reset();
    din_a = 1'b1;
    base = edge_cnt;
    push_a(1'b1, base + 6);
    push_a(1'b0, base + 10);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("min_level", int'(level_a), int'(k >= 6 && k < 10));
      check("min_busy", int'(busy_a), int'((k >= 3 && k <= 5) || (k >= 7 && k <= 9)));
      check("min_fall", int'(fall_a), int'(k == 10));
      if (k == 4) din_a = 1'b0;
    end

    // Bounce during confirm restarts the count.
    do_reset();
    din_a = 1'b1;
    base = edge_cnt;
    push_a(1'b1, base + 9);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 2) din_a = 1'b0;
      if (k == 3) din_a = 1'b1;
      check("bounce_level", int'(level_a), int'(k >= 9));
      check("bounce_busy", int'(busy_a), int'(k == 3 || k == 4 || (k >= 6 && k <= 8)));
    end

    // Reset in the middle of a confirm.
    do_reset();
    din_a = 1'b1;
    base = edge_cnt;
    repeat (4) @(negedge clk);
    check("midrst_busy_before", int'(busy_a), 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy_now", int'(busy_a), 0);
    check("midrst_level_now", int'(level_a), 0);
    check("midrst_pulses_now", int'(rise_a) + int'(fall_a), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = edge_cnt;
    push_a(1'b1, base + 6);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("midrst_level", int'(level_a), int'(k >= 6));
    end

    // Parameter boundary: SYNC_STAGES=3, DEBOUNCE_CYCLES=2.
    do_reset();
    din_b = 1'b1;
    base = edge_cnt;
    push_b(1'b1, base + 5);
    push_b(1'b0, base + 11);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("p_level", int'(level_b), int'(k >= 5 && k < 11));
      check("p_busy", int'(busy_b), int'(k == 4 || k == 10));
      if (k == 6) din_b = 1'b0;
    end
    din_b = 1'b1;
    base = edge_cnt;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) din_b = 1'b0;
      check("p_glitch_level", int'(level_b), 0);
      check("p_glitch_busy", int'(busy_b), int'(k == 4));
    end

    repeat (2) @(negedge clk);
    check("final_queue_a", q_a.size(), 0);
    check("final_queue_b", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
